// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read path: default word width and a constant-safe
// ceil(log2) used to size skid-buffer pointers.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_fifo_buf.sv
// Small register-file FIFO that absorbs the async FIFO's read latency. Pointers carry an extra
// wrap bit so count = wr - rd distinguishes full from empty without a separate flag.
module skid_fifo_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = 4,
    localparam int unsigned PTR_W     = clog2(BUF_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [PTR_W:0]        o_count
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;
    logic                  w_full;

    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (o_count == (PTR_W + 1)'(BUF_DEPTH));
    assign o_head_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
                r_wr_ptr                   <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Issue throttling upstream keeps occupancy below depth; either firing is a design error.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && w_full && !i_pop));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_pop && (o_count == '0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the async FIFO: throttled pop issue, one-cycle latency absorbed in a
// skid buffer, and a valid/ready stream with burst framing, word counter and sticky error.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                  i_rd_clk,
    input  logic                  i_rd_rst,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_rd_valid,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    output logic                  o_m_last,
    input  logic                  i_m_ready,
    output logic [15:0]           o_words_out,
    output logic                  o_err
);

    localparam int unsigned PTR_W   = clog2(BUF_DEPTH);
    localparam int unsigned BURST_W = clog2(BURST_LEN + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
    localparam logic [PTR_W+1:0]   OCC_LIMIT  = (PTR_W + 2)'(BUF_DEPTH - 1);

    logic [PTR_W:0]        w_count;
    logic [PTR_W+1:0]      w_occupancy;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  r_inflight;
    logic [BURST_W-1:0]    r_burst_cnt;
    logic [15:0]           r_words_out;
    logic                  r_err;

    // Buffered plus in-flight words; the pending read must always find a free slot.
    assign w_occupancy  = {1'b0, w_count} + {{(PTR_W + 1){1'b0}}, r_inflight};
    assign o_fifo_rd_en = ~i_rd_rst & i_enable & ~i_fifo_empty & (w_occupancy < OCC_LIMIT);

    assign w_push      = i_fifo_rd_valid & r_inflight;
    assign o_m_valid   = (w_count != '0);
    assign w_pop       = o_m_valid & i_m_ready;
    assign o_m_data    = w_head;
    assign o_m_last    = o_m_valid & (r_burst_cnt == BURST_LAST);
    assign o_words_out = r_words_out;
    assign o_err       = r_err;

    skid_fifo_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk       (i_rd_clk),
        .i_rst       (i_rd_rst),
        .i_push      (w_push),
        .i_push_data (i_fifo_rd_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
        if (i_rd_rst) begin
            r_inflight  <= 1'b0;
            r_burst_cnt <= '0;
            r_words_out <= '0;
            r_err       <= 1'b0;
        end else begin
            r_inflight <= o_fifo_rd_en;
            // Data with no outstanding pop cannot be placed in order, so it is dropped.
            if (i_fifo_rd_valid && !r_inflight) begin
                r_err <= 1'b1;
            end
            if (w_pop) begin
                r_words_out <= r_words_out + 16'd1;
                r_burst_cnt <= (r_burst_cnt == BURST_LAST) ? '0 : r_burst_cnt + 1'b1;
            end
        end
    end

endmodule
